// File: rtl/hls_deadlock_monitor_gen2.sv
// Per-process deadlock monitor for HLS dataflow regions: registered block, persistence filter, sticky flag.
// Optional stall-cycle statistics are enabled with DEADLOCK_MON_STALL_STATS_EN.
module hls_deadlock_monitor_gen2 #(
  parameter int                  NUM_AXIS  = 4,
  parameter int                  NUM_INST  = 3,
  parameter int                  IDLE_W    = 6,
  parameter logic [NUM_AXIS-1:0] AXIS_MASK = 4'b0011,
  parameter int                  THRESHOLD = 16,
  parameter int                  CNT_W     = 8,
  parameter int                  IDX_W     = 3
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [NUM_AXIS-1:0] axis_block_sigs,
  input  logic [IDLE_W-1:0]   inst_idle_sigs,
  input  logic [NUM_INST-1:0] inst_block_sigs,
  input  logic                clear,
  output logic                block,
  output logic                deadlock,
  output logic [IDX_W-1:0]    first_idx,
  output logic [CNT_W-1:0]    persist_cnt
`ifdef DEADLOCK_MON_STALL_STATS_EN
  ,
  output logic [31:0]         stall_cycles
`endif
);

  localparam int              OFF_W = NUM_AXIS + NUM_INST;
  localparam logic [CNT_W-1:0] THR  = CNT_W'(THRESHOLD);

  typedef enum logic [1:0] {IDLE, WATCH, DEADLOCK} state_t;

  state_t             state, state_nxt;
  logic [OFF_W-1:0]   off_vec;
  logic [IDX_W-1:0]   off_idx;
  logic               cand;
  logic [CNT_W-1:0]   cnt_inc;
  logic [CNT_W-1:0]   cnt_nxt;
  logic               dl_nxt;
  logic [IDX_W-1:0]   idx_nxt;

  assign off_vec = {inst_block_sigs, axis_block_sigs & AXIS_MASK};
  assign cand    = (|off_vec) & ~(&inst_idle_sigs);
  assign cnt_inc = persist_cnt + CNT_W'(1);

  // Scan from the top so the lowest set bit is the last one written.
  always_comb begin
    off_idx = '0;
    for (int i = OFF_W - 1; i >= 0; i--) begin
      if (off_vec[i]) off_idx = IDX_W'(i);
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = persist_cnt;
    dl_nxt    = deadlock;
    idx_nxt   = first_idx;
    if (clear) begin
      state_nxt = IDLE;
      cnt_nxt   = '0;
      dl_nxt    = 1'b0;
      idx_nxt   = '0;
    end else begin
      case (state)
        IDLE: begin
          if (cand) begin
            cnt_nxt = CNT_W'(1);
            if (THR == CNT_W'(1)) begin
              state_nxt = DEADLOCK;
              dl_nxt    = 1'b1;
              idx_nxt   = off_idx;
            end else begin
              state_nxt = WATCH;
            end
          end else begin
            cnt_nxt = '0;
          end
        end
        WATCH: begin
          if (!cand) begin
            state_nxt = IDLE;
            cnt_nxt   = '0;
          end else if (cnt_inc == THR) begin
            state_nxt = DEADLOCK;
            dl_nxt    = 1'b1;
            idx_nxt   = off_idx;
            cnt_nxt   = THR;
          end else begin
            cnt_nxt = cnt_inc;
          end
        end
        DEADLOCK: ;
        default: begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
          dl_nxt    = 1'b0;
          idx_nxt   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= IDLE;
      block       <= 1'b0;
      deadlock    <= 1'b0;
      first_idx   <= '0;
      persist_cnt <= '0;
    end else begin
      state       <= state_nxt;
      block       <= cand;
      deadlock    <= dl_nxt;
      first_idx   <= idx_nxt;
      persist_cnt <= cnt_nxt;
    end
  end

`ifdef DEADLOCK_MON_STALL_STATS_EN
  // Counts in every state, including DEADLOCK; saturates rather than wrapping.
  always_ff @(posedge clock) begin
    if (reset || clear) begin
      stall_cycles <= '0;
    end else if (cand && (stall_cycles != 32'hFFFF_FFFF)) begin
      stall_cycles <= stall_cycles + 32'd1;
    end
  end
`endif

endmodule
